// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_scoreboard slice.
// Optional same-cycle write bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

   localparam int SEL_MAX_W = 8;

   // Select index wide enough for the largest supported depth (256).
   typedef logic [SEL_MAX_W-1:0] sel_t;

   localparam int DEFAULT_ALU_A_IDX = 1;
   localparam int DEFAULT_ALU_B_IDX = 2;
   localparam int DEFAULT_ALU_R_IDX = 3;

   function automatic logic in_range(input sel_t sel, input int unsigned depth);
      return 32'(sel) < depth;
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: select mux over the register array, busy lookup
// and, with REGFILE_BYPASS_EN defined, a same-cycle write-data bypass.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 6,
   parameter int SELW  = $clog2(DEPTH)
) (
   input  logic [SELW-1:0]  sel,
   input  logic [WIDTH-1:0] regs [DEPTH],
   input  logic [DEPTH-1:0] busy,
   input  logic             wr_en,
   input  logic [SELW-1:0]  wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rsv_en,
   input  logic [SELW-1:0]  rsv_sel,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_busy
);

`ifndef REGFILE_BYPASS_EN
   logic unused_bypass;
   assign unused_bypass = ^{wr_en, wr_sel, wr_data, rsv_en, rsv_sel};
`endif

   always_comb begin
      rd_data = '0;
      rd_busy = 1'b0;
      if (in_range(sel_t'(sel), DEPTH)) begin
         rd_data = regs[sel];
         rd_busy = busy[sel];
`ifdef REGFILE_BYPASS_EN
         // sel is in range here, so a matching wr_sel is in range too.
         if (wr_en && (wr_sel == sel)) begin
            rd_data = wr_data;
            rd_busy = rsv_en && (rsv_sel == sel);
         end
`endif
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with NREAD combinational read ports, one write
// port and a per-register busy scoreboard. Define REGFILE_BYPASS_EN for write bypass.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 6,
   parameter int NREAD     = 2,
   parameter int ALU_A_IDX = DEFAULT_ALU_A_IDX,
   parameter int ALU_B_IDX = DEFAULT_ALU_B_IDX,
   parameter int ALU_R_IDX = DEFAULT_ALU_R_IDX,
   localparam int SELW     = $clog2(DEPTH)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [SELW-1:0]        wr_sel,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rsv_en,
   input  logic [SELW-1:0]        rsv_sel,
   input  logic                   err_clear,
   input  logic [NREAD*SELW-1:0]  rd_sel,
   output logic [NREAD*WIDTH-1:0] rd_data,
   output logic [NREAD-1:0]       rd_busy,
   output logic [DEPTH-1:0]       busy,
   output logic                   rsv_conflict,
   output logic [WIDTH-1:0]       aluoperandA,
   output logic [WIDTH-1:0]       aluoperandB,
   output logic [WIDTH-1:0]       aluresult
);

   if (ALU_A_IDX >= DEPTH || ALU_B_IDX >= DEPTH || ALU_R_IDX >= DEPTH) begin : g_bad_tap
      $error("regfile_scoreboard: ALU tap index out of range for DEPTH=%0d", DEPTH);
   end

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy_next;
   logic             wr_ok;
   logic             rsv_ok;
   logic             conflict_now;

   assign wr_ok  = wr_en  && in_range(sel_t'(wr_sel), DEPTH);
   assign rsv_ok = rsv_en && in_range(sel_t'(rsv_sel), DEPTH);

   // A same-edge write to the reserved index is a back-to-back issue, not a conflict.
   assign conflict_now = rsv_ok && busy[rsv_sel] && !(wr_ok && (wr_sel == rsv_sel));

   always_comb begin
      busy_next = busy;
      if (wr_ok)  busy_next[wr_sel]  = 1'b0;
      if (rsv_ok) busy_next[rsv_sel] = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy         <= '0;
         rsv_conflict <= 1'b0;
      end else begin
         if (wr_ok) regs[wr_sel] <= wr_data;
         busy <= busy_next;
         if (conflict_now)   rsv_conflict <= 1'b1;
         else if (err_clear) rsv_conflict <= 1'b0;
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      regfile_read_port #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .SELW  (SELW)
      ) u_port (
         .sel     (rd_sel[i*SELW +: SELW]),
         .regs    (regs),
         .busy    (busy),
         .wr_en   (wr_en),
         .wr_sel  (wr_sel),
         .wr_data (wr_data),
         .rsv_en  (rsv_en),
         .rsv_sel (rsv_sel),
         .rd_data (rd_data[i*WIDTH +: WIDTH]),
         .rd_busy (rd_busy[i])
      );
   end

   always_comb begin
      aluoperandA = regs[ALU_A_IDX];
      aluoperandB = regs[ALU_B_IDX];
      aluresult   = regs[ALU_R_IDX];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wr_sel == SELW'(ALU_A_IDX))) aluoperandA = wr_data;
      if (wr_en && (wr_sel == SELW'(ALU_B_IDX))) aluoperandB = wr_data;
      if (wr_en && (wr_sel == SELW'(ALU_R_IDX))) aluresult   = wr_data;
`endif
   end

endmodule
